// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match, auto-reload and interrupt request.
// Optional PWM output and CTRL[3] PWM_INV are enabled by defining TIMER_PWM_EN.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] wData,
    output logic [31:0] rData,
    output logic        hit,
    output logic        irq
`ifdef TIMER_PWM_EN
    ,
    output logic        pwm_o
`endif
);

`ifdef TIMER_PWM_EN
    localparam int CTRL_W = 4;
`else
    localparam int CTRL_W = 3;
`endif

    logic [CTRL_W-1:0]  ctrl, ctrl_next;
    logic [PRESC_W-1:0] presc, presc_next;
    logic [PRESC_W-1:0] pcnt, pcnt_next;
    logic [31:0]        count, count_next;
    logic [31:0]        compare, compare_next;
    logic               match, match_next;
    logic               irq_next;
    logic               tick;
    logic               wr;
    logic               presc_wr;
    logic               count_wr;
    logic               match_set;
    logic               w1c;
    logic [2:0]         off;
    logic [31:0]        lane_mask;
    logic               unused_addr_bits;

    assign hit              = ce && (addr[31:5] == BASE_ADDR[31:5]);
    assign wr               = hit && we;
    assign off              = addr[4:2];
    assign unused_addr_bits = ^addr[1:0];
    assign lane_mask        = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};

    assign presc_wr  = wr && (off == 3'd1);
    assign count_wr  = wr && (off == 3'd2) && (sel != 4'b0000);
    assign tick      = ctrl[0] && (pcnt == presc);
    // A CPU write to COUNT suppresses both the increment and the match check on that edge.
    assign match_set = tick && !count_wr && (count == compare);
    assign w1c       = wr && (off == 3'd4) && sel[0] && wData[0];

    // Next-state computation for all timer registers.
    always_comb begin
        ctrl_next    = ctrl;
        presc_next   = presc;
        compare_next = compare;
        count_next   = count;
        match_next   = match;
        pcnt_next    = pcnt;

        if (wr && (off == 3'd0)) begin
            ctrl_next = (ctrl & ~lane_mask[CTRL_W-1:0]) | (wData[CTRL_W-1:0] & lane_mask[CTRL_W-1:0]);
        end else begin
            ctrl_next = ctrl;
        end

        if (presc_wr) begin
            presc_next = (presc & ~lane_mask[PRESC_W-1:0]) | (wData[PRESC_W-1:0] & lane_mask[PRESC_W-1:0]);
        end else begin
            presc_next = presc;
        end

        if (wr && (off == 3'd3)) begin
            compare_next = (compare & ~lane_mask) | (wData & lane_mask);
        end else begin
            compare_next = compare;
        end

        if (count_wr) begin
            count_next = (count & ~lane_mask) | (wData & lane_mask);
        end else if (match_set) begin
            count_next = ctrl[1] ? 32'h0000_0000 : count + 32'd1;
        end else if (tick) begin
            count_next = count + 32'd1;
        end else begin
            count_next = count;
        end

        // A match on the same edge as the clear wins.
        if (match_set) begin
            match_next = 1'b1;
        end else if (w1c) begin
            match_next = 1'b0;
        end else begin
            match_next = match;
        end

        if (!ctrl[0] || presc_wr || tick) begin
            pcnt_next = {PRESC_W{1'b0}};
        end else begin
            pcnt_next = pcnt + PRESC_W'(1);
        end
    end

    assign irq_next = match_next & ctrl[2];

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl    <= {CTRL_W{1'b0}};
            presc   <= {PRESC_W{1'b0}};
            pcnt    <= {PRESC_W{1'b0}};
            count   <= 32'h0000_0000;
            compare <= 32'hFFFF_FFFF;
            match   <= 1'b0;
            irq     <= 1'b0;
        end else begin
            ctrl    <= ctrl_next;
            presc   <= presc_next;
            pcnt    <= pcnt_next;
            count   <= count_next;
            compare <= compare_next;
            match   <= match_next;
            irq     <= irq_next;
        end
    end

`ifdef TIMER_PWM_EN
    // PWM output: high while counting below COMPARE, optionally inverted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_o <= 1'b0;
        end else begin
            pwm_o <= (ctrl[0] && (count < compare)) ^ ctrl[3];
        end
    end
`endif

    // Read mux reflects pre-edge register state.
    always_comb begin
        rData = 32'h0000_0000;
        if (hit && !we) begin
            case (off)
                3'd0:    rData = 32'(ctrl);
                3'd1:    rData = 32'(presc);
                3'd2:    rData = count;
                3'd3:    rData = compare;
                3'd4:    rData = {31'h0000_0000, match};
                default: rData = 32'h0000_0000;
            endcase
        end else begin
            rData = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios then random bus traffic,
// all compared against a cycle-level behavioural model of the register map.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef TIMER_PWM_EN
    localparam logic [31:0] CTRL_MASK = 32'h0000_000F;
`else
    localparam logic [31:0] CTRL_MASK = 32'h0000_0007;
`endif

    logic        clk = 1'b0;
    logic        rst, ce, we, hit, irq;
    logic [31:0] addr, wData, rData;
    logic [3:0]  sel;
`ifdef TIMER_PWM_EN
    logic        pwm_o;
`endif

    always #5 clk = ~clk;

    mmio_timer dut (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .we    (we),
        .addr  (addr),
        .sel   (sel),
        .wData (wData),
        .rData (rData),
        .hit   (hit),
        .irq   (irq)
`ifdef TIMER_PWM_EN
        ,
        .pwm_o (pwm_o)
`endif
    );

    // Behavioural model state
    logic [31:0] m_ctrl, m_presc, m_count, m_cmp;
    logic        m_match, m_irq, m_pwm;
    int unsigned m_phase;

    int vec = 0;
    int bad = 0;
    logic [31:0] last_rd;
    logic        last_irq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] off);
        case (off)
            3'd0:    return m_ctrl;
            3'd1:    return m_presc;
            3'd2:    return m_count;
            3'd3:    return m_cmp;
            3'd4:    return {31'h0, m_match};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic c, input logic w,
                              input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] nc, np, ncount, ncmp;
        logic nmatch, hm, wa, tk, cw, setm;
        int unsigned nphase;
        if (r) begin
            m_ctrl = 0; m_presc = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
            m_match = 0; m_irq = 0; m_pwm = 0; m_phase = 0;
            return;
        end
        hm = c && (a[31:5] == BASE[31:5]);
        wa = hm && w;
        // A tick is the last cycle of every (PRESCALE+1)-cycle window since enabling.
        tk = m_ctrl[0] && ((m_phase % (m_presc + 1)) == m_presc);
        nc = m_ctrl; np = m_presc; ncmp = m_cmp; ncount = m_count; nmatch = m_match; setm = 0;
        cw = wa && (a[4:2] == 3'd2) && (s != 4'b0);
        if (cw) ncount = lanes(m_count, d, s);
        else if (tk) begin
            if (m_count == m_cmp) begin
                setm = 1;
                ncount = m_ctrl[1] ? 32'h0 : m_count + 32'd1;
            end else ncount = m_count + 32'd1;
        end
        if (setm) nmatch = 1;
        else if (wa && (a[4:2] == 3'd4) && s[0] && d[0]) nmatch = 0;
        if (wa) begin
            case (a[4:2])
                3'd0:    nc   = lanes(m_ctrl, d, s) & CTRL_MASK;
                3'd1:    np   = lanes(m_presc, d, s) & 32'h0000_FFFF;
                3'd3:    ncmp = lanes(m_cmp, d, s);
                default: ;
            endcase
        end
        nphase = (!m_ctrl[0] || (wa && (a[4:2] == 3'd1))) ? 0 : m_phase + 1;
        m_irq = nmatch & m_ctrl[2];
        m_pwm = (m_ctrl[0] && (m_count < m_cmp)) ^ m_ctrl[3];
        m_ctrl = nc; m_presc = np; m_cmp = ncmp; m_count = ncount; m_match = nmatch; m_phase = nphase;
    endtask

    task automatic cyc(input logic r, input logic c, input logic w,
                       input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic eh;
        rst = r; ce = c; we = w; addr = a; sel = s; wData = d;
        #1;
        eh = c && (a[31:5] == BASE[31:5]);
        last_rd = rData;
        chk("hit", {31'h0, hit}, {31'h0, eh});
        chk("rdata", rData, (eh && !w) ? model_read(a[4:2]) : 32'h0);
        @(posedge clk);
        model_edge(r, c, w, a, s, d);
        #1;
        last_irq = irq;
        chk("irq", {31'h0, irq}, {31'h0, m_irq});
`ifdef TIMER_PWM_EN
        chk("pwm", {31'h0, pwm_o}, {31'h0, m_pwm});
`endif
    endtask

    task automatic wr(input logic [2:0] off, input logic [3:0] s, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b1, BASE + {27'h0, off, 2'b00}, s, d);
    endtask

    task automatic rd(input logic [2:0] off);
        cyc(1'b0, 1'b1, 1'b0, BASE + {27'h0, off, 2'b00}, 4'hF, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_irq", {31'h0, last_irq}, 32'h0);
        rd(3'd2); chk("rst_count", last_rd, 32'h0);
        rd(3'd3); chk("rst_compare", last_rd, 32'hFFFF_FFFF);
        rd(3'd0); chk("rst_ctrl", last_rd, 32'h0);

        // Prescale 3, compare 5, irq enabled
        wr(3'd1, 4'hF, 32'd3);
        wr(3'd3, 4'hF, 32'd5);
        wr(3'd0, 4'hF, 32'h5);
        idle(26);
        rd(3'd2); chk("presc_count6", last_rd, 32'd6);
        rd(3'd4); chk("presc_match", last_rd, 32'd1);
        chk("presc_irq", {31'h0, last_irq}, 32'h1);

        // Auto-reload with W1C
        do_reset();
        wr(3'd1, 4'hF, 32'd0);
        wr(3'd3, 4'hF, 32'd2);
        wr(3'd0, 4'hF, 32'h7);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            rd(3'd2);
            chk("reload_seq", last_rd, 32'(i));
        end
        rd(3'd4); chk("reload_match", last_rd, 32'd1);
        wr(3'd4, 4'h1, 32'h1);
        chk("w1c_irq_drop", {31'h0, last_irq}, 32'h0);
        wr(3'd4, 4'h1, 32'h1);
        rd(3'd4); chk("w1c_vs_match", last_rd, 32'd1);

        // Byte lanes
        do_reset();
        wr(3'd3, 4'hF, 32'h0);
        wr(3'd3, 4'b0101, 32'hAABB_CCDD);
        rd(3'd3); chk("byte_lanes", last_rd, 32'h00BB_00DD);

        // Wrap and write-vs-tick priority
        wr(3'd2, 4'hF, 32'hFFFF_FFFF);
        wr(3'd3, 4'hF, 32'd3);
        wr(3'd1, 4'hF, 32'd0);
        wr(3'd0, 4'hF, 32'h1);
        idle(1);
        rd(3'd2); chk("wrap_zero", last_rd, 32'h0);
        rd(3'd4); chk("wrap_nomatch", last_rd, 32'h0);
        wr(3'd2, 4'hF, 32'd7);
        rd(3'd2); chk("write_beats_tick", last_rd, 32'd7);

        // Unmapped offset and deselected bus
        rd(3'd6); chk("unmapped", last_rd, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, BASE + 32'h8, 4'hF, 32'h0);
        chk("ce_low", last_rd, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h2000_0008, 4'hF, 32'h0);
        chk("out_of_window", last_rd, 32'h0);

`ifdef TIMER_PWM_EN
        do_reset();
        wr(3'd1, 4'hF, 32'd0);
        wr(3'd3, 4'hF, 32'd4);
        wr(3'd0, 4'hF, 32'h3);
        idle(20);
`endif

        // Random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int unsigned kind;
            logic [2:0]  off;
            logic [31:0] a, d;
            logic [3:0]  s;
            kind = $urandom_range(0, 99);
            off  = 3'($urandom_range(0, 7));
            a    = BASE + {27'h0, off, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 19) == 0) a = a ^ 32'h0000_0100;
            s    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            case (off)
                3'd0:    d = 32'($urandom_range(0, 15)) | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
                3'd1:    d = 32'($urandom_range(0, 3));
                3'd2:    d = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                                         : 32'($urandom_range(0, 12));
                3'd3:    d = 32'($urandom_range(0, 12));
                default: d = $urandom;
            endcase
            if (kind < 2)       cyc(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            else if (kind < 35) cyc(1'b0, ($urandom_range(0, 9) != 0), 1'b1, a, s, d);
            else if (kind < 70) cyc(1'b0, ($urandom_range(0, 9) != 0), 1'b0, a, s, 32'h0);
            else                cyc(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
